// File: rtl/gate_bist_pkg.sv
// Shared definitions for the logic-gate BIST sequencer and its reference model.
package gate_bist_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bist_state_t;

endpackage

// File: rtl/logic_gate_ref.sv
// Golden 2-input gate function; also used by gate benches as a reference model.
module logic_gate_ref
    import gate_bist_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] f
);

    always_comb begin
        f = '0;
        case (op)
            OP_AND: f = a & b;
            OP_OR:  f = a | b;
            OP_XOR: f = a ^ b;
            OP_NOR: f = ~(a | b);
        endcase
    end

endmodule

// File: rtl/logic_gate_bist_ctrl.sv
// Exhaustive-vector BIST sequencer for one 2-input gate under test.
//
// state | meaning
// IDLE  | waiting for start; results of the last run held
// RUN   | stepping vectors, waiting DUT_LAT clocks then scoring each one
// DONE  | one-cycle end of run; done pulse, pass valid
module logic_gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int DUT_LAT = 0,
    parameter int ERR_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           op_sel,
    output logic [WIDTH-1:0]     a_o,
    output logic [WIDTH-1:0]     b_o,
    input  logic [WIDTH-1:0]     f_i,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_cnt,
    output logic [2*WIDTH-1:0]   first_fail
);

    localparam int VEC_W  = 2 * WIDTH;
    localparam int WAIT_W = (DUT_LAT < 1) ? 1 : $clog2(DUT_LAT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(DUT_LAT);

    bist_state_t         state, state_nxt;
    logic [VEC_W-1:0]    vec;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [1:0]          op_q;
    logic [WIDTH-1:0]    f_ref;
    logic                sample;
    logic                last_vec;
    logic                mismatch;
    logic [ERR_W-1:0]    err_nxt;

    logic_gate_ref #(.WIDTH(WIDTH)) u_ref (
        .op (op_q),
        .a  (a_o),
        .b  (b_o),
        .f  (f_ref)
    );

    // Operands are straight slices of the registered vector counter.
    assign a_o      = vec[VEC_W-1:WIDTH];
    assign b_o      = vec[WIDTH-1:0];
    assign sample   = (state == RUN) && (wait_cnt == '0);
    assign last_vec = (vec == '1);
    assign mismatch = (f_i != f_ref);

    always_comb begin
        err_nxt = err_cnt;
        if (mismatch && (err_cnt != '1)) begin
            err_nxt = err_cnt + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (sample && last_vec) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec        <= '0;
            wait_cnt   <= '0;
            op_q       <= '0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            first_fail <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q       <= op_sel;
                        vec        <= '0;
                        wait_cnt   <= WAIT_LOAD;
                        pass       <= 1'b0;
                        err_cnt    <= '0;
                        first_fail <= '0;
                    end
                end
                RUN: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end else begin
                        err_cnt <= err_nxt;
                        // err_cnt never returns to zero within a run, so zero marks the first miss
                        if (mismatch && (err_cnt == '0)) begin
                            first_fail <= vec;
                        end
                        if (!last_vec) begin
                            vec      <= vec + VEC_W'(1);
                            wait_cnt <= WAIT_LOAD;
                        end else begin
                            pass <= (err_nxt == '0);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
